bkm_step_ctrl: RTL and testbench

Sequencer for the bkm_data_step datapath in the xfire BKM FPU. It loads the initial X/Y operands and holds the iteration registers X_n/Y_n. It drives the step index n and step enable, and feeds X_np1/Y_np1 back for N_ITER iterations. The final result is presented through a valid/ack handshake.

---
 rtl/bkm_step_ctrl.sv | 175 +++++++++++++++++
 tb/tb_bkm_step_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bkm_step_ctrl.sv
// bkm_step_ctrl: iteration sequencer for the BKM datapath.
// Holds X_n/Y_n, steps index n through N_ITER evaluations of bkm_data_step,
// then parks the final X/Y in a result register offered through valid/ack.
module bkm_step_ctrl #(
   parameter int W      = 64,
   parameter int N_ITER = 64,
   parameter int CNT_W  = 7
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             srst,
   input  logic             enable,
   input  logic             start,
   input  logic             abort,
   input  logic [W-1:0]     X_0,
   input  logic [W-1:0]     Y_0,
   input  logic [W-1:0]     X_np1,
   input  logic [W-1:0]     Y_np1,
   output logic [W-1:0]     X_n,
   output logic [W-1:0]     Y_n,
   output logic [CNT_W-1:0] n,
   output logic             step_en,
   output logic             busy,
   output logic [W-1:0]     X_res,
   output logic [W-1:0]     Y_res,
   output logic             res_valid,
   input  logic             res_ack,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   // Index of the last step; the counter returns to zero here instead of wrapping.
   localparam logic [CNT_W-1:0] LAST_N = CNT_W'(N_ITER - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_n;
   logic [W-1:0]     r_xn;
   logic [W-1:0]     r_yn;
   logic [W-1:0]     r_xres;
   logic [W-1:0]     r_yres;
   logic             r_valid;
   logic             r_done;

   state_t           w_state_next;
   logic [CNT_W-1:0] w_n_next;
   logic [W-1:0]     w_xn_next;
   logic [W-1:0]     w_yn_next;
   logic [W-1:0]     w_xres_next;
   logic [W-1:0]     w_yres_next;
   logic             w_valid_next;
   logic             w_done_next;
   logic             w_step_en;
   logic             w_last_step;

   assign w_last_step = (r_n == LAST_N);

   // Next-state and next-register values; everything holds unless enable is high.
   always_comb begin
      w_state_next = r_state;
      w_n_next     = r_n;
      w_xn_next    = r_xn;
      w_yn_next    = r_yn;
      w_xres_next  = r_xres;
      w_yres_next  = r_yres;
      w_valid_next = r_valid;
      w_done_next  = r_done;
      w_step_en    = 1'b0;

      if (enable) begin
         // done is a single enabled-cycle pulse, so any enabled cycle clears it
         // unless the completion branch below sets it again.
         w_done_next = 1'b0;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_xn_next    = X_0;
                  w_yn_next    = Y_0;
                  w_n_next     = '0;
                  w_state_next = S_ITER;
               end
            end

            S_ITER: begin
               w_step_en = 1'b1;
               if (abort) begin
                  // Abort wins even on the final step: no result is published.
                  w_n_next     = '0;
                  w_valid_next = 1'b0;
                  w_done_next  = 1'b0;
                  w_state_next = S_IDLE;
               end else begin
                  w_xn_next = X_np1;
                  w_yn_next = Y_np1;
                  if (w_last_step) begin
                     w_xres_next  = X_np1;
                     w_yres_next  = Y_np1;
                     w_valid_next = 1'b1;
                     w_done_next  = 1'b1;
                     w_n_next     = '0;
                     w_state_next = S_HOLD;
                  end else begin
                     w_n_next = r_n + 1'b1;
                  end
               end
            end

            S_HOLD: begin
               // A start arriving with the ack is dropped; it must be
               // presented again once the block is back in IDLE.
               if (abort || res_ack) begin
                  w_valid_next = 1'b0;
                  w_done_next  = 1'b0;
                  w_n_next     = '0;
                  w_state_next = S_IDLE;
               end
            end

            default: begin
               w_n_next     = '0;
               w_valid_next = 1'b0;
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers: async reset first, then sync reset, then update.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state <= S_IDLE;
         r_n     <= '0;
         r_xn    <= '0;
         r_yn    <= '0;
         r_xres  <= '0;
         r_yres  <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else if (srst) begin
         r_state <= S_IDLE;
         r_n     <= '0;
         r_xn    <= '0;
         r_yn    <= '0;
         r_xres  <= '0;
         r_yres  <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_n     <= w_n_next;
         r_xn    <= w_xn_next;
         r_yn    <= w_yn_next;
         r_xres  <= w_xres_next;
         r_yres  <= w_yres_next;
         r_valid <= w_valid_next;
         r_done  <= w_done_next;
      end
   end

   assign X_n       = r_xn;
   assign Y_n       = r_yn;
   assign n         = r_n;
   assign step_en   = w_step_en;
   assign busy      = (r_state == S_ITER) || (r_state == S_HOLD);
   assign X_res     = r_xres;
   assign Y_res     = r_yres;
   assign res_valid = r_valid;
   assign done      = r_done;

endmodule

// File: tb/tb_bkm_step_ctrl.sv
// Bench for bkm_step_ctrl: two instances (N_ITER=4 and N_ITER=1) share one
// control stream; each is compared every cycle against an operation-level model.
module tb_bkm_step_ctrl;

   localparam int W = 64;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HOLD = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         arst, srst, enable, start, abort, res_ack;
   logic [W-1:0] x0, y0;

   // instance a: N_ITER=4, stub X_np1 = X_n + n, Y_np1 = Y_n - 1
   logic [W-1:0] a_xn, a_yn, a_xnp1, a_ynp1, a_xres, a_yres;
   logic [2:0]   a_n;
   logic         a_se, a_busy, a_valid, a_done;
   // instance b: N_ITER=1, stub X_np1 = X_n + 7, Y_np1 = Y_n - 1
   logic [W-1:0] b_xn, b_yn, b_xnp1, b_ynp1, b_xres, b_yres;
   logic [0:0]   b_n;
   logic         b_se, b_busy, b_valid, b_done;

   assign a_xnp1 = a_xn + W'(a_n);
   assign a_ynp1 = a_yn - 64'd1;
   assign b_xnp1 = b_xn + 64'd7;
   assign b_ynp1 = b_yn - 64'd1;

   bkm_step_ctrl #(.W(W), .N_ITER(4), .CNT_W(3)) u_a (
      .clk(clk), .arst(arst), .srst(srst), .enable(enable), .start(start),
      .abort(abort), .X_0(x0), .Y_0(y0), .X_np1(a_xnp1), .Y_np1(a_ynp1),
      .X_n(a_xn), .Y_n(a_yn), .n(a_n), .step_en(a_se), .busy(a_busy),
      .X_res(a_xres), .Y_res(a_yres), .res_valid(a_valid), .res_ack(res_ack),
      .done(a_done));

   bkm_step_ctrl #(.W(W), .N_ITER(1), .CNT_W(1)) u_b (
      .clk(clk), .arst(arst), .srst(srst), .enable(enable), .start(start),
      .abort(abort), .X_0(x0), .Y_0(y0), .X_np1(b_xnp1), .Y_np1(b_ynp1),
      .X_n(b_xn), .Y_n(b_yn), .n(b_n), .step_en(b_se), .busy(b_busy),
      .X_res(b_xres), .Y_res(b_yres), .res_valid(b_valid), .res_ack(res_ack),
      .done(b_done));

   int checks = 0;
   int errors = 0;

   // Operation-level model: which phase, how many steps done, operands of the op.
   int           m_mode  [2];
   int           m_steps [2];
   logic [W-1:0] m_opx   [2];
   logic [W-1:0] m_opy   [2];
   logic [W-1:0] m_xres  [2];
   logic [W-1:0] m_yres  [2];
   bit           m_valid [2];
   bit           m_done  [2];
   int           niter   [2] = '{4, 1};

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // X after s steps of the stub datapath, in closed form.
   function automatic logic [W-1:0] exp_x(input int d, input logic [W-1:0] xs, input int s);
      logic [W-1:0] s64;
      s64 = W'(s);
      if (d == 0) return xs + (s64 * (s64 - 64'd1)) / 64'd2;
      return xs + 64'd7 * s64;
   endfunction

   task automatic model_reset(input int d);
      m_mode[d]  = M_IDLE;
      m_steps[d] = 0;
      m_opx[d]   = '0;
      m_opy[d]   = '0;
      m_xres[d]  = '0;
      m_yres[d]  = '0;
      m_valid[d] = 1'b0;
      m_done[d]  = 1'b0;
   endtask

   task automatic model_step(input int d);
      if (arst || srst) begin
         model_reset(d);
      end else if (enable) begin
         m_done[d] = 1'b0;
         if (m_mode[d] == M_IDLE) begin
            if (start) begin
               m_opx[d]   = x0;
               m_opy[d]   = y0;
               m_steps[d] = 0;
               m_mode[d]  = M_RUN;
            end
         end else if (m_mode[d] == M_RUN) begin
            if (abort) begin
               m_mode[d]  = M_IDLE;
               m_valid[d] = 1'b0;
            end else begin
               m_steps[d]++;
               if (m_steps[d] == niter[d]) begin
                  m_xres[d]  = exp_x(d, m_opx[d], m_steps[d]);
                  m_yres[d]  = m_opy[d] - W'(m_steps[d]);
                  m_valid[d] = 1'b1;
                  m_done[d]  = 1'b1;
                  m_mode[d]  = M_HOLD;
                  $display("op dut%0d complete x_res=%0h y_res=%0h", d, m_xres[d], m_yres[d]);
               end
            end
         end else begin
            if (abort || res_ack) begin
               m_mode[d]  = M_IDLE;
               m_valid[d] = 1'b0;
            end
         end
      end
   endtask

   task automatic check_dut(input int d, input logic [W-1:0] xn, input logic [W-1:0] yn,
                            input logic [W-1:0] nn, input logic se, input logic bz,
                            input logic [W-1:0] xr, input logic [W-1:0] yr,
                            input logic rv, input logic dn);
      string p;
      p = (d == 0) ? "a" : "b";
      chk({p, ".X_n"}, xn, exp_x(d, m_opx[d], m_steps[d]));
      chk({p, ".Y_n"}, yn, m_opy[d] - W'(m_steps[d]));
      chk({p, ".n"}, nn, (m_mode[d] == M_RUN) ? W'(m_steps[d]) : 64'd0);
      chk({p, ".step_en"}, W'(se), W'((m_mode[d] == M_RUN) && enable && !arst));
      chk({p, ".busy"}, W'(bz), W'(m_mode[d] != M_IDLE));
      chk({p, ".X_res"}, xr, m_xres[d]);
      chk({p, ".Y_res"}, yr, m_yres[d]);
      chk({p, ".res_valid"}, W'(rv), W'(m_valid[d]));
      chk({p, ".done"}, W'(dn), W'(m_done[d]));
   endtask

   task automatic check_all();
      check_dut(0, a_xn, a_yn, W'(a_n), a_se, a_busy, a_xres, a_yres, a_valid, a_done);
      check_dut(1, b_xn, b_yn, W'(b_n), b_se, b_busy, b_xres, b_yres, b_valid, b_done);
   endtask

   // One clock: check outputs before the edge, advance the model at the edge.
   task automatic cycle();
      #1;
      check_all();
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
   endtask

   initial begin
      arst = 1'b1; srst = 1'b0; enable = 1'b1; start = 1'b0; abort = 1'b0;
      res_ack = 1'b0; x0 = '0; y0 = '0;
      model_reset(0);
      model_reset(1);
      @(negedge clk);
      #1;
      check_all();
      @(negedge clk);
      arst = 1'b0;

      // basic operation: 4 steps, X_res = 10+0+1+2+3, Y_res = 100-4
      x0 = 64'd10; y0 = 64'd100; start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (4) cycle();
      chk("t1.a_xres", a_xres, 64'd16);
      chk("t1.a_yres", a_yres, 64'd96);
      chk("t1.a_done", W'(a_done), 64'd1);
      cycle();
      chk("t1.a_done_low", W'(a_done), 64'd0);
      chk("t1.a_valid", W'(a_valid), 64'd1);

      // long HOLD, start during HOLD ignored, start together with ack ignored
      repeat (8) cycle();
      start = 1'b1;
      cycle();
      start = 1'b0;
      chk("t2.a_busy", W'(a_busy), 64'd1);
      res_ack = 1'b1; start = 1'b1;
      cycle();
      res_ack = 1'b0; start = 1'b0;
      chk("t2.a_idle", W'(a_busy), 64'd0);
      chk("t2.a_xres_kept", a_xres, 64'd16);
      cycle();
      chk("t2.a_still_idle", W'(a_busy), 64'd0);

      // enable toggling during ITER
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         enable = (i % 2 == 0);
         cycle();
      end
      enable = 1'b1;
      chk("t3.a_valid", W'(a_valid), 64'd1);
      chk("t3.a_xres", a_xres, 64'd16);
      res_ack = 1'b1;
      cycle();
      res_ack = 1'b0;

      // abort mid-run at n==2, then abort on the final step
      x0 = 64'd33; y0 = 64'd7; start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (2) cycle();
      chk("t4.a_n2", W'(a_n), 64'd2);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("t4.a_idle", W'(a_busy), 64'd0);
      chk("t4.a_xres_kept", a_xres, 64'd16);
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (3) cycle();
      chk("t4.a_n3", W'(a_n), 64'd3);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("t4.a_no_done", W'(a_done), 64'd0);
      chk("t4.a_no_valid", W'(a_valid), 64'd0);
      chk("t4.a_xres_final", a_xres, 64'd16);

      // asynchronous reset between edges with n==1
      x0 = 64'd50; y0 = 64'd60; start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      #2;
      arst = 1'b1;
      #1;
      model_reset(0);
      model_reset(1);
      chk("t5.a_xn_async", a_xn, 64'd0);
      check_all();
      @(negedge clk);
      arst = 1'b0;

      // synchronous reset in HOLD
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (4) cycle();
      chk("t5.a_valid_hold", W'(a_valid), 64'd1);
      srst = 1'b1;
      cycle();
      srst = 1'b0;
      chk("t5.a_valid_srst", W'(a_valid), 64'd0);

      // single-iteration instance, then back-to-back operation after ack
      x0 = 64'd5; y0 = 64'd9; start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      chk("t6.b_valid", W'(b_valid), 64'd1);
      chk("t6.b_xres", b_xres, 64'd12);
      res_ack = 1'b1;
      cycle();
      res_ack = 1'b0;
      x0 = 64'd20; start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      chk("t6.b_xres2", b_xres, 64'd27);
      chk("t6.b_yres2", b_yres, 64'd8);

      // randomized control traffic
      for (int i = 0; i < 3000; i++) begin
         enable  = ($urandom_range(0, 9) != 0);
         start   = ($urandom_range(0, 2) == 0);
         abort   = ($urandom_range(0, 29) == 0);
         res_ack = ($urandom_range(0, 3) == 0);
         srst    = ($urandom_range(0, 199) == 0);
         x0      = {$urandom, $urandom};
         y0      = {$urandom, $urandom};
         cycle();
      end
      enable = 1'b1; start = 1'b0; abort = 1'b0; res_ack = 1'b0; srst = 1'b0;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
